// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle between a timer user and countdown_timer
interface countdown_timer_if;
   logic       tick;
   logic       load;
   logic [6:0] load_val;
   logic       start;
   logic       stop;
   logic [6:0] count;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       running;
   logic       done;

   modport master (
      output tick, load, load_val, start, stop,
      input  count, tens, ones, running, done
   );

   modport slave (
      input  tick, load, load_val, start, stop,
      output count, tens, ones, running, done
   );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - pausable countdown timer with binary and BCD remaining-count outputs
// Binary count and BCD digits are separate down counters kept in lockstep.
module countdown_timer #(
   parameter int MAX_VAL = 99
) (
   input  logic             CLK,
   input  logic             rst,
   countdown_timer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [6:0] C_MAX = 7'(MAX_VAL);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [6:0] r_count;
   logic [6:0] w_count_nxt;
   logic [3:0] r_tens;
   logic [3:0] w_tens_nxt;
   logic [3:0] r_ones;
   logic [3:0] w_ones_nxt;
   logic       r_done;
   logic       w_done_nxt;
   logic [6:0] w_load_val;
   logic [7:0] w_load_bcd;

   // Load-time conversion only; 0..99 resolved by threshold compares, no divider.
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      logic [3:0] t;
      logic [3:0] rem;
      t   = 4'd0;
      rem = v[3:0];
      for (int k = 9; k >= 1; k--) begin
         if (t == 4'd0 && v >= 7'(k * 10)) begin
            t   = 4'(k);
            rem = 4'(v - 7'(k * 10));
         end
      end
      return {t, rem};
   endfunction

   always_comb begin
      w_load_val = (bus.load_val > C_MAX) ? C_MAX : bus.load_val;
      w_load_bcd = to_bcd(w_load_val);
   end

   // Requests that have no effect in the current state fall through to the next priority.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_tens_nxt  = r_tens;
      w_ones_nxt  = r_ones;
      w_done_nxt  = 1'b0;
      if (bus.load) begin
         w_state_nxt = IDLE;
         w_count_nxt = w_load_val;
         w_tens_nxt  = w_load_bcd[7:4];
         w_ones_nxt  = w_load_bcd[3:0];
      end else if (bus.stop && r_state == RUN) begin
         w_state_nxt = PAUSE;
      end else if (bus.start && (r_state == IDLE || r_state == PAUSE) && r_count != 7'd0) begin
         w_state_nxt = RUN;
      end else if (bus.tick && r_state == RUN) begin
         if (r_count > 7'd1) begin
            w_count_nxt = r_count - 7'd1;
            if (r_ones == 4'd0) begin
               w_ones_nxt = 4'd9;
               w_tens_nxt = r_tens - 4'd1;
            end else begin
               w_ones_nxt = r_ones - 4'd1;
            end
         end else begin
            w_state_nxt = DONE;
            w_count_nxt = 7'd0;
            w_tens_nxt  = 4'd0;
            w_ones_nxt  = 4'd0;
            w_done_nxt  = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= 7'd0;
         r_tens  <= 4'd0;
         r_ones  <= 4'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_tens  <= w_tens_nxt;
         r_ones  <= w_ones_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.count   = r_count;
   assign bus.tens    = r_tens;
   assign bus.ones    = r_ones;
   assign bus.running = (r_state == RUN);
   assign bus.done    = r_done;
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer against a behavioural model
module tb_countdown_timer;
   localparam int MAXV = 99;

   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
   typedef struct {
      int count;
      int tens;
      int ones;
      int running;
      int done;
   } exp_t;

   logic CLK = 1'b0;
   logic rst = 1'b1;
   countdown_timer_if ifc();

   countdown_timer #(.MAX_VAL(MAXV)) dut (
      .CLK (CLK),
      .rst (rst),
      .bus (ifc)
   );

   always #5 CLK = ~CLK;

   exp_t    q[$];
   int      n_checks = 0;
   int      n_err    = 0;
   int      m_count  = 0;
   int      m_done   = 0;
   mstate_t m_st     = M_IDLE;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one step per rising edge, expected outputs queued for the monitor.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         m_done = 0;
         if (rst) begin
            m_count = 0;
            m_st    = M_IDLE;
         end else if (ifc.load) begin
            m_count = (int'(ifc.load_val) > MAXV) ? MAXV : int'(ifc.load_val);
            m_st    = M_IDLE;
         end else if (ifc.stop && m_st == M_RUN) begin
            m_st = M_PAUSE;
         end else if (ifc.start && (m_st == M_IDLE || m_st == M_PAUSE) && m_count > 0) begin
            m_st = M_RUN;
         end else if (ifc.tick && m_st == M_RUN) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_st   = M_DONE;
               m_done = 1;
            end
         end
         e.count   = m_count;
         e.tens    = m_count / 10;
         e.ones    = m_count % 10;
         e.running = (m_st == M_RUN) ? 1 : 0;
         e.done    = m_done;
         q.push_back(e);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() == 0) begin
            chk("scoreboard_entries", 0, 1);
         end else begin
            e = q.pop_front();
            chk("count",   int'(ifc.count),   e.count);
            chk("tens",    int'(ifc.tens),    e.tens);
            chk("ones",    int'(ifc.ones),    e.ones);
            chk("running", int'(ifc.running), e.running);
            chk("done",    int'(ifc.done),    e.done);
         end
      end
   end

   task automatic drive(input bit rs, input bit ld, input int lv, input bit st, input bit sp,
                        input bit tk);
      @(negedge CLK);
      rst          = rs;
      ifc.load     = ld;
      ifc.load_val = 7'(lv);
      ifc.start    = st;
      ifc.stop     = sp;
      ifc.tick     = tk;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      ifc.load = 0; ifc.load_val = 0; ifc.start = 0; ifc.stop = 0; ifc.tick = 0;
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      idle(1);

      // load 12 and run to expiry, then ticks in DONE
      drive(0, 1, 12, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      idle(2);

      // clamp, and start ignored at zero
      drive(0, 1, 120, 0, 0, 0);
      idle(1);
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1);

      // pause: stop wins over tick, ticks ignored in PAUSE, resume
      drive(0, 1, 50, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1);

      // load beats stop and tick
      drive(0, 1, 10, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
      drive(0, 1, 30, 0, 1, 1);
      idle(1);

      // 10 -> 9 digit borrow, then expiry from 1 with a tick on the done cycle
      drive(0, 1, 10, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 1, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);

      // reset held across the expiry edge suppresses done
      drive(0, 1, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 1);
      idle(1);

      // asynchronous reset pulse between edges while running at 25
      drive(0, 1, 25, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      idle(1);
      @(posedge CLK);
      #3;
      rst = 1'b1;
      #1;
      chk("async_count",   int'(ifc.count),   0);
      chk("async_tens",    int'(ifc.tens),    0);
      chk("async_ones",    int'(ifc.ones),    0);
      chk("async_running", int'(ifc.running), 0);
      chk("async_done",    int'(ifc.done),    0);
      m_count = 0;
      m_st    = M_IDLE;
      rst     = 1'b0;
      drive(0, 0, 0, 1, 0, 0);
      idle(1);

      for (int i = 0; i < 2000; i++) begin
         int lv;
         lv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 127));
         drive($urandom_range(0, 255) == 0,
               $urandom_range(0, 19) == 0,
               lv,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 1) == 0);
      end

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
